uart_msg_arbiter: RTL and testbench

Shares the single `uart_tx` serialiser between up to `N_REQ` message sources, for example the switch-driven JSON command sender and a telemetry source. Each source streams its message byte by byte. The arbiter grants the UART to one source at a time, round-robin, and holds the grant for the whole message so that bytes from different messages never interleave. It sits between the message generators and `uart_tx` in the top level, and replaces the ad-hoc ready-edge sequencing with a proper valid/ready handshake.

---
 rtl/uart_msg_pkg.sv | 13 +
 rtl/rr_picker.sv | 33 +++
 rtl/uart_msg_arbiter.sv | 125 ++++++++++++
 tb/tb_uart_msg_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_msg_pkg.sv
// Shared types and defaults for the UART message arbiter.
package uart_msg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  localparam int MAX_LEN_DEF    = 64;
  localparam int GAP_CYCLES_DEF = 0;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first requesting index at or after ptr,
// wrapping around. Reusable by any shared-resource arbiter.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  gnt_id,
  output logic             any
);

  localparam logic [ID_W:0] N_EXT = (ID_W+1)'(N_REQ);

  logic [N_REQ-1:0] w_rot;
  logic [ID_W-1:0]  w_off;
  logic [ID_W:0]    w_sum;

  // Rotate so that bit 0 is the lane at ptr; the lowest set bit then wins.
  assign w_rot = N_REQ'({req, req} >> ptr);

  always_comb begin
    w_off = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (w_rot[i]) w_off = ID_W'(i);
    end
  end

  assign w_sum  = {1'b0, ptr} + {1'b0, w_off};
  assign gnt_id = (w_sum >= N_EXT) ? ID_W'(w_sum - N_EXT) : w_sum[ID_W-1:0];
  assign any    = |req;

endmodule

// File: rtl/uart_msg_arbiter.sv
// Round-robin arbiter sharing one uart_tx between several byte-streaming
// message sources; a grant is held for a whole message.
module uart_msg_arbiter
  import uart_msg_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int BITS_N     = 8,
  parameter int MAX_LEN    = MAX_LEN_DEF,
  parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*BITS_N-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic [BITS_N-1:0]         tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      overrun
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_LEN+1);
  localparam int GAP_W = $clog2(GAP_CYCLES+2);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ-1);
  localparam logic [CNT_W-1:0] LEN_LAST = CNT_W'(MAX_LEN-1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES-1 : 0);

  arb_state_t        r_state, w_state_nxt;
  logic [ID_W-1:0]   r_grant_id, r_rr_ptr, w_pick_id;
  logic              w_any;
  logic [CNT_W-1:0]  r_byte_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic              r_hold_valid, r_hold_last, r_hold_ovr, r_overrun;
  logic [BITS_N-1:0] r_hold_data;
  logic              w_sel_valid, w_sel_last;
  logic [BITS_N-1:0] w_sel_data;
  logic              w_load, w_drain;

  rr_picker #(.N_REQ(N_REQ), .ID_W(ID_W)) u_picker (
    .req    (req_valid),
    .ptr    (r_rr_ptr),
    .gnt_id (w_pick_id),
    .any    (w_any)
  );

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_last  = 1'b0;
    w_sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant_id == ID_W'(i)) begin
        w_sel_valid = req_valid[i];
        w_sel_last  = req_last[i];
        w_sel_data  = req_data[i*BITS_N +: BITS_N];
      end
    end
  end

  assign w_drain = r_hold_valid && tx_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    req_ready   = '0;
    case (r_state)
      IDLE: if (w_any) w_state_nxt = SEND;
      SEND: begin
        w_load    = !r_hold_valid && w_sel_valid;
        req_ready = w_load ? (N_REQ'(1) << r_grant_id) : '0;
        // A length-forced abort leaves SEND exactly like a real last byte.
        if (w_drain && (r_hold_last || r_hold_ovr))
          w_state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: if (r_gap_cnt == '0) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_grant_id   <= '0;
      r_rr_ptr     <= '0;
      r_byte_cnt   <= '0;
      r_gap_cnt    <= '0;
      r_hold_valid <= 1'b0;
      r_hold_last  <= 1'b0;
      r_hold_ovr   <= 1'b0;
      r_hold_data  <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_overrun <= w_drain && r_hold_ovr;
      if (r_state == IDLE && w_any) begin
        r_grant_id <= w_pick_id;
        r_rr_ptr   <= (w_pick_id == LAST_ID) ? '0 : w_pick_id + 1'b1;
        r_byte_cnt <= '0;
      end
      if (w_load) begin
        r_hold_valid <= 1'b1;
        r_hold_data  <= w_sel_data;
        r_hold_last  <= w_sel_last;
        r_hold_ovr   <= !w_sel_last && (r_byte_cnt == LEN_LAST);
        r_byte_cnt   <= r_byte_cnt + 1'b1;
      end else if (w_drain) begin
        r_hold_valid <= 1'b0;
      end
      if (r_state != GAP)
        r_gap_cnt <= GAP_LOAD;
      else if (r_gap_cnt != '0)
        r_gap_cnt <= r_gap_cnt - 1'b1;
    end
  end

  assign tx_valid = r_hold_valid;
  assign tx_data  = r_hold_data;
  assign busy     = (r_state != IDLE);
  assign grant_id = r_grant_id;
  assign overrun  = r_overrun;

endmodule

// File: tb/tb_uart_msg_arbiter.sv
// Scoreboard bench for uart_msg_arbiter: lane drivers feed byte queues,
// a UART model applies back-pressure and a monitor checks each accepted byte.
module tb_uart_msg_arbiter;

  localparam int N_REQ      = 4;
  localparam int BITS_N     = 8;
  localparam int MAX_LEN    = 24;
  localparam int GAP_CYCLES = 5;
  localparam int UART_BUSY  = 10;
  localparam int WAIT_MAX   = 5000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_last, req_ready;
  logic [31:0] req_data;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, busy, overrun;
  logic [1:0]  grant_id;

  always #5 clk = ~clk;

  uart_msg_arbiter #(
    .N_REQ(N_REQ), .BITS_N(BITS_N), .MAX_LEN(MAX_LEN), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .grant_id(grant_id), .overrun(overrun)
  );

  typedef struct packed {logic [7:0] data; logic last;} byte_t;
  typedef struct packed {logic [1:0] id; logic [7:0] data; logic ends;} exp_t;

  byte_t lane_q[4][$];
  exp_t  exp_q[$];
  logic [3:0] pause;
  int n_vec, n_err, ovr_cycles, gap_cnt;
  logic in_gap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Bytes: 0x7B first, 0x0A last, lane-tagged filler in between.
  task automatic push_msg(input int lane, input int len);
    byte_t b;
    exp_t  e;
    for (int i = 0; i < len; i++) begin
      b.data = (i == 0) ? 8'h7B : (i == len-1) ? 8'h0A : 8'(lane*64 + i);
      b.last = (i == len-1);
      lane_q[lane].push_back(b);
      e.id   = 2'(lane);
      e.data = b.data;
      e.ends = b.last || ((i+1) % MAX_LEN == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    check({name, "_timeout"}, 32'(n >= WAIT_MAX), 0);
  endtask

  // Lane drivers: consume on the handshake, present the next byte after the edge.
  initial begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      for (int l = 0; l < 4; l++)
        if (req_valid[l] && req_ready[l] && lane_q[l].size() > 0)
          void'(lane_q[l].pop_front());
      @(posedge clk);
      #1;
      for (int l = 0; l < 4; l++) begin
        if (lane_q[l].size() > 0 && !pause[l]) begin
          req_valid[l]        = 1'b1;
          req_data[l*8 +: 8]  = lane_q[l][0].data;
          req_last[l]         = lane_q[l][0].last;
        end else begin
          req_valid[l]        = 1'b0;
          req_data[l*8 +: 8]  = '0;
          req_last[l]         = 1'b0;
        end
      end
    end
  end

  // UART model: ready drops for UART_BUSY cycles after each accepted byte.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_valid && tx_ready) begin
        @(posedge clk);
        #1 tx_ready = 1'b0;
        repeat (UART_BUSY-1) @(posedge clk);
        #1 tx_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      in_gap = 1'b0;
    end else begin
      if (overrun) ovr_cycles++;
      if (in_gap) begin
        if (busy) begin
          gap_cnt++;
          check("gap_req_ready", 32'(req_ready), 0);
        end else begin
          check("gap_len", gap_cnt, GAP_CYCLES);
          in_gap = 1'b0;
        end
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_byte: actual id %0d data %02h, required none", grant_id, tx_data);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", {22'd0, grant_id, tx_data}, {22'd0, e.id, e.data});
          if (e.ends) begin
            in_gap  = 1'b1;
            gap_cnt = 0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_vec = 0; n_err = 0; ovr_cycles = 0; gap_cnt = 0;
    in_gap = 1'b0; pause = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_tx_valid",  32'(tx_valid), 0);
    check("rst_busy",      32'(busy), 0);
    check("rst_grant_id",  32'(grant_id), 0);
    check("rst_overrun",   32'(overrun), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_tx_data",   32'(tx_data), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Contention from reset: lane 1 then lane 3, with request-to-byte latency.
    push_msg(1, 3);
    push_msg(3, 3);
    @(negedge clk);
    check("c0_busy", 32'(busy), 0);
    check("c0_req_valid", 32'(req_valid), 32'b1010);
    @(negedge clk);
    check("c1_busy", 32'(busy), 1);
    check("c1_grant", 32'(grant_id), 1);
    check("c1_req_ready", 32'(req_ready), 32'b0010);
    @(negedge clk);
    check("c2_tx_valid", 32'(tx_valid), 1);
    wait_done("contention1");

    // rr_ptr back at 0: lanes 0, 1, 3 in order.
    push_msg(0, 2);
    push_msg(1, 2);
    push_msg(3, 2);
    wait_done("contention2");

    push_msg(0, 24);
    wait_done("single");
    check("single_no_overrun", ovr_cycles, 0);

    // Stall: lane 0 pauses mid-message while lane 2 waits.
    push_msg(0, 6);
    n = 0;
    while (lane_q[0].size() > 3 && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    pause[0] = 1'b1;
    push_msg(2, 2);
    repeat (50) @(negedge clk);
    check("stall_grant", 32'(grant_id), 0);
    check("stall_busy", 32'(busy), 1);
    check("stall_pending", exp_q.size(), 5);
    pause[0] = 1'b0;
    wait_done("stall");

    // Overrun: 26 bytes with MAX_LEN 24 splits into 24 + 2.
    ovr_cycles = 0;
    push_msg(1, 26);
    wait_done("overrun");
    check("overrun_pulses", ovr_cycles, 1);

    // Async reset while a byte is presented to the UART.
    push_msg(2, 5);
    n = 0;
    while (!tx_valid && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    check("pre_reset_tx_valid", 32'(tx_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tx_valid", 32'(tx_valid), 0);
    check("arst_busy", 32'(busy), 0);
    exp_q.delete();
    for (int l = 0; l < 4; l++) lane_q[l].delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_msg(0, 2);
    push_msg(3, 2);
    repeat (2) @(negedge clk);
    check("post_reset_grant", 32'(grant_id), 0);
    wait_done("post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
